// File: rtl/fifo_pkt_pkg.sv
// fifo_pkt_pkg: shared state encoding, default sizes and checksum fold for the packet FIFO writer and reader
package fifo_pkt_pkg;

    typedef enum logic [1:0] {IDLE, HDR, BODY, TRL} state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_MAX_LEN = 64;

    // One step of the XOR checksum; the read side folds received payload words the same way.
    function automatic logic [DEF_WIDTH-1:0] csum_fold(input logic [DEF_WIDTH-1:0] acc,
                                                       input logic [DEF_WIDTH-1:0] d);
        return acc ^ d;
    endfunction

endpackage

// File: rtl/fifo_pkt_writer_csum.sv
// pkt_csum_acc: XOR checksum accumulator for one packet payload
//   wr_clk/reset  clock, async active-high reset
//   clr_i         restart the checksum at zero (takes priority over en_i)
//   en_i, data_i  fold data_i into the checksum
//   csum_o        registered checksum
//   csum_next_o   value the checksum takes at the next edge
module pkt_csum_acc #(
    parameter int WIDTH = 8
) (
    input  logic             wr_clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] csum_o,
    output logic [WIDTH-1:0] csum_next_o
);

    logic [WIDTH-1:0] csum_q;

    assign csum_next_o = clr_i ? '0 : en_i ? csum_q ^ data_i : csum_q;
    assign csum_o      = csum_q;

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_next_o;
    end

endmodule

// File: rtl/fifo_pkt_writer.sv
// fifo_pkt_writer: frames an upstream byte stream into header/payload/checksum-trailer FIFO writes
//   wr_clk/reset             clock, async active-high reset
//   s_valid_i/s_data_i/s_last_i/s_ready_o  upstream valid/ready stream framed by last
//   wr_full_i/wr_en_o/wr_data_o            async FIFO write port
//   busy_o       not idle
//   trunc_err_o  pulses with the write of the MAX_LEN-th word of a packet that had no last there
//   pkt_count_o  packets whose trailer has been written, wrapping
module fifo_pkt_writer
    import fifo_pkt_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = 7,
    parameter int CNT_W   = 16
) (
    input  logic             wr_clk,
    input  logic             reset,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    input  logic             wr_full_i,
    output logic             wr_en_o,
    output logic [WIDTH-1:0] wr_data_o,
    output logic             busy_o,
    output logic             trunc_err_o,
    output logic [CNT_W-1:0] pkt_count_o
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seq_q, seq_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] csum, csum_next;
    logic             xfer, at_max;

    assign xfer   = (state_q == BODY) & s_valid_i & !wr_full_i;
    assign at_max = (len_q + LEN_W'(1)) == LEN_W'(MAX_LEN);

    assign s_ready_o   = (state_q == BODY) & !wr_full_i;
    assign wr_en_o     = !wr_full_i & ((state_q == HDR) | (state_q == TRL) | ((state_q == BODY) & s_valid_i));
    assign wr_data_o   = state_q == HDR  ? seq_q :
                         state_q == BODY ? s_data_i :
                         state_q == TRL  ? csum_next : '0;
    assign busy_o      = state_q != IDLE;
    assign trunc_err_o = xfer & !s_last_i & at_max;
    assign pkt_count_o = cnt_q;

    pkt_csum_acc #(.WIDTH(WIDTH)) u_csum (
        .wr_clk      (wr_clk),
        .reset       (reset),
        .clr_i       ((state_q == HDR) & !wr_full_i),
        .en_i        (xfer),
        .data_i      (s_data_i),
        .csum_o      (csum),
        .csum_next_o (csum_next)
    );

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (s_valid_i) state_d = HDR;
            HDR: if (!wr_full_i) begin
                seq_d   = seq_q + WIDTH'(1);
                len_d   = '0;
                state_d = BODY;
            end
            BODY: if (xfer) begin
                len_d = len_q + LEN_W'(1);
                if (s_last_i || at_max) state_d = TRL;
            end
            TRL: if (!wr_full_i) begin
                cnt_d   = cnt_q + CNT_W'(1);
                // a waiting upstream word goes straight to a new header, no idle gap
                state_d = s_valid_i ? HDR : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            seq_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// tb_fifo_pkt_writer: randomized self-checking bench with a packet-level reference model
module tb_fifo_pkt_writer;

    localparam int MAXL = 64;

    logic        wr_clk = 0;
    logic        reset = 1;
    logic        s_valid = 0;
    logic [7:0]  s_data = 0;
    logic        s_last = 0;
    logic        s_ready;
    logic        wr_full = 0;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        busy;
    logic        trunc_err;
    logic [15:0] pkt_count;

    fifo_pkt_writer dut (
        .wr_clk      (wr_clk),
        .reset       (reset),
        .s_valid_i   (s_valid),
        .s_data_i    (s_data),
        .s_last_i    (s_last),
        .s_ready_o   (s_ready),
        .wr_full_i   (wr_full),
        .wr_en_o     (wr_en),
        .wr_data_o   (wr_data),
        .busy_o      (busy),
        .trunc_err_o (trunc_err),
        .pkt_count_o (pkt_count)
    );

    always #5 wr_clk = ~wr_clk;

    int checks = 0, errors = 0;
    int cyc = 0, viol = 0, tcnt = 0, tidx = -1;
    int full_pct = 0, force_full = 0;
    logic [7:0]  got[$], exp[$];
    int          gcyc[$];
    logic [7:0]  mseq = 0;
    logic [15:0] mpkts = 0;
    int          mtrunc = 0;

    always @(posedge wr_clk) cyc++;

    always @(negedge wr_clk) if (!reset) begin
        if (wr_en) begin
            got.push_back(wr_data);
            gcyc.push_back(cyc);
        end
        if (wr_full && (wr_en || s_ready)) viol++;
        if (trunc_err) begin
            tcnt++;
            tidx = got.size() - 1;
        end
    end

    // Expected FIFO writes for one upstream packet: split into MAX_LEN chunks, each framed by seq and XOR.
    task model_pkt(input logic [7:0] w[$]);
        logic [7:0] c;
        int n;
        bit open;
        open = 0; c = 0; n = 0;
        for (int i = 0; i < w.size(); i++) begin
            if (!open) begin
                exp.push_back(mseq);
                mseq++;
                c = 0; n = 0; open = 1;
            end
            exp.push_back(w[i]);
            c ^= w[i];
            n++;
            if (i == w.size() - 1 || n == MAXL) begin
                exp.push_back(c);
                mpkts++;
                if (i != w.size() - 1) mtrunc++;
                open = 0;
            end
        end
    endtask

    task tick();
        @(posedge wr_clk);
        #1;
        if (force_full > 0) begin
            wr_full = 1;
            force_full--;
        end else wr_full = (full_pct > 0) && ($urandom_range(0, 99) < full_pct);
    endtask

    task clear_obs();
        got.delete(); gcyc.delete(); exp.delete();
        tcnt = 0; tidx = -1; mtrunc = 0;
    endtask

    task apply_reset();
        reset = 1; s_valid = 0; s_last = 0; wr_full = 0;
        repeat (2) @(posedge wr_clk);
        #1 reset = 0;
        mseq = 0; mpkts = 0;
        clear_obs();
    endtask

    task drive(input logic [7:0] w[$], input int stall_idx, input bit with_last);
        int n;
        bit acc;
        for (int i = 0; i < w.size(); i++) begin
            s_valid = 1;
            s_data  = w[i];
            s_last  = with_last && (i == w.size() - 1);
            acc = 0; n = 0;
            while (!acc) begin
                @(negedge wr_clk);
                acc = s_ready;
                tick();
                n++;
                if (n > 2000) begin
                    errors++;
                    $display("FAIL drive_timeout word %0d not accepted after %0d cycles", i, n);
                    s_valid = 0;
                    return;
                end
            end
            if (i == stall_idx) force_full = 3;
        end
        s_valid = 0;
        s_last  = 0;
    endtask

    task drain();
        int n;
        full_pct = 0; s_valid = 0; n = 0;
        forever begin
            @(negedge wr_clk);
            if (!busy) break;
            tick();
            if (++n > 500) begin
                errors++;
                $display("FAIL drain_timeout busy still 1 after %0d cycles, need 0", n);
                break;
            end
        end
        tick();
    endtask

    task test_reset();
        apply_reset();
        @(negedge wr_clk);
        checks += 6;
        if (wr_en !== 0)     begin errors++; $display("FAIL reset_wr_en got %b need 0", wr_en); end
        if (s_ready !== 0)   begin errors++; $display("FAIL reset_s_ready got %b need 0", s_ready); end
        if (busy !== 0)      begin errors++; $display("FAIL reset_busy got %b need 0", busy); end
        if (trunc_err !== 0) begin errors++; $display("FAIL reset_trunc got %b need 0", trunc_err); end
        if (wr_data !== 0)   begin errors++; $display("FAIL reset_wr_data got %h need 00", wr_data); end
        if (pkt_count !== 0) begin errors++; $display("FAIL reset_pkt_count got %0d need 0", pkt_count); end
        tick();
    endtask

    task test_basic();
        logic [7:0] w[$];
        w = '{8'h12, 8'h34, 8'h56};
        exp = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h70};
        mseq = 1; mpkts = 1;
        full_pct = 0;
        drive(w, -1, 1);
        @(negedge wr_clk);
        checks++;
        if (!(wr_en === 1 && wr_data === 8'h70)) begin errors++; $display("FAIL basic_trailer got en=%b data=%h need en=1 data=70", wr_en, wr_data); end
        tick();
        @(negedge wr_clk);
        checks += 3;
        if (busy !== 0) begin errors++; $display("FAIL basic_busy_drop got %b need 0", busy); end
        if (pkt_count !== 16'd1) begin errors++; $display("FAIL basic_pkt_count got %0d need 1", pkt_count); end
        if (got.size() != 5) begin errors++; $display("FAIL basic_len got %0d need 5", got.size()); end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL basic_word%0d got %h need %h", i, got[i], exp[i]); end
        end
        if (gcyc.size() == 5) begin
            checks++;
            if (gcyc[4] - gcyc[0] != 4) begin errors++; $display("FAIL basic_contig span got %0d need 4", gcyc[4] - gcyc[0]); end
        end
        tick();
        clear_obs();
    endtask

    task test_stall();
        logic [7:0] w[$];
        w = '{8'h12, 8'h34, 8'h56};
        viol = 0;
        model_pkt(w);
        drive(w, 0, 1);
        drain();
        checks += 3;
        if (viol != 0) begin errors++; $display("FAIL stall_write_while_full got %0d need 0", viol); end
        if (got.size() != exp.size()) begin errors++; $display("FAIL stall_len got %0d need %0d", got.size(), exp.size()); end
        if (got.size() > 4 && got[4] !== 8'h70) begin errors++; $display("FAIL stall_csum got %h need 70", got[4]); end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL stall_word%0d got %h need %h", i, got[i], exp[i]); end
        end
        clear_obs();
    endtask

    task test_trunc();
        logic [7:0] w[$];
        for (int i = 0; i < 66; i++) w.push_back(8'($urandom));
        model_pkt(w);
        drive(w, -1, 1);
        drain();
        checks += 4;
        if (tcnt != 1) begin errors++; $display("FAIL trunc_pulses got %0d need 1", tcnt); end
        if (tidx != 64) begin errors++; $display("FAIL trunc_position got %0d need 64", tidx); end
        if (pkt_count !== mpkts) begin errors++; $display("FAIL trunc_pkt_count got %0d need %0d", pkt_count, mpkts); end
        if (got.size() != exp.size()) begin errors++; $display("FAIL trunc_len got %0d need %0d", got.size(), exp.size()); end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL trunc_word%0d got %h need %h", i, got[i], exp[i]); end
        end
        clear_obs();
    endtask

    task test_back_to_back();
        logic [7:0] a[$], b[$];
        apply_reset();
        a = '{8'hA5};
        b = '{8'h5A};
        model_pkt(a);
        model_pkt(b);
        drive(a, -1, 1);
        drive(b, -1, 1);
        drain();
        checks += 2;
        if (got.size() != 6) begin errors++; $display("FAIL b2b_len got %0d need 6", got.size()); end
        if (gcyc.size() == 6 && gcyc[5] - gcyc[0] != 5) begin errors++; $display("FAIL b2b_gap span got %0d need 5", gcyc[5] - gcyc[0]); end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL b2b_word%0d got %h need %h", i, got[i], exp[i]); end
        end
        clear_obs();
    endtask

    task test_reset_mid();
        logic [7:0] w[$];
        w = '{8'h11, 8'h22};
        drive(w, -1, 0);
        reset = 1;
        #1;
        checks += 6;
        if (wr_en !== 0)     begin errors++; $display("FAIL rstmid_wr_en got %b need 0", wr_en); end
        if (s_ready !== 0)   begin errors++; $display("FAIL rstmid_s_ready got %b need 0", s_ready); end
        if (busy !== 0)      begin errors++; $display("FAIL rstmid_busy got %b need 0", busy); end
        if (trunc_err !== 0) begin errors++; $display("FAIL rstmid_trunc got %b need 0", trunc_err); end
        if (wr_data !== 0)   begin errors++; $display("FAIL rstmid_wr_data got %h need 00", wr_data); end
        if (pkt_count !== 0) begin errors++; $display("FAIL rstmid_pkt_count got %0d need 0", pkt_count); end
        @(posedge wr_clk);
        #1 reset = 0;
        mseq = 0; mpkts = 0;
        clear_obs();
        w = '{8'h77};
        model_pkt(w);
        drive(w, -1, 1);
        drain();
        checks++;
        if (got.size() != 3) begin errors++; $display("FAIL rstmid_len got %0d need 3", got.size()); end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL rstmid_word%0d got %h need %h", i, got[i], exp[i]); end
        end
        clear_obs();
    endtask

    task test_seq_wrap();
        logic [7:0] w[$];
        apply_reset();
        for (int p = 0; p < 256; p++) begin
            w = '{8'($urandom)};
            model_pkt(w);
            drive(w, -1, 1);
        end
        drain();
        checks += 3;
        if (pkt_count !== 16'd256) begin errors++; $display("FAIL wrap_pkt_count got %0d need 256", pkt_count); end
        if (got.size() != 768) begin errors++; $display("FAIL wrap_len got %0d need 768", got.size()); end
        if (got.size() > 765 && got[765] !== 8'hFF) begin errors++; $display("FAIL wrap_last_hdr got %h need ff", got[765]); end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL wrap_word%0d got %h need %h", i, got[i], exp[i]); end
        end
        clear_obs();
    endtask

    task test_random();
        logic [7:0] w[$];
        viol = 0;
        for (int p = 0; p < 20; p++) begin
            w.delete();
            for (int i = 0; i < int'($urandom_range(1, 140)); i++) w.push_back(8'($urandom));
            model_pkt(w);
            full_pct = 30;
            drive(w, -1, 1);
            if ($urandom_range(0, 1) == 0) drain();
        end
        drain();
        checks += 4;
        if (viol != 0) begin errors++; $display("FAIL rand_write_while_full got %0d need 0", viol); end
        if (tcnt != mtrunc) begin errors++; $display("FAIL rand_trunc_count got %0d need %0d", tcnt, mtrunc); end
        if (pkt_count !== mpkts) begin errors++; $display("FAIL rand_pkt_count got %0d need %0d", pkt_count, mpkts); end
        if (got.size() != exp.size()) begin errors++; $display("FAIL rand_len got %0d need %0d", got.size(), exp.size()); end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL rand_word%0d got %h need %h", i, got[i], exp[i]); end
        end
        clear_obs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_trunc();
        test_back_to_back();
        test_reset_mid();
        test_seq_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
